z80_int_arbiter: RTL and testbench

//  Multi-source interrupt controller for the Z80 bus. Collects level requests

---
 rtl/z80_int_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_z80_int_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/z80_int_arbiter.sv
// z80_int_arbiter
//   Multi-source interrupt controller for the Z80 bus. Level requests from
//   on-FPGA peripherals are masked, INT_n is raised to the CPU, and the
//   winning source's vector is supplied during the interrupt acknowledge
//   cycle (M1_n and IORQ_n both low). The top-level data mux takes vec_out
//   when vec_oe=1 and io_rd_data when io_rd_sel=1.
//
// Configuration macro:
//   INT_RR_PRIO_EN - rotating priority (search starts at a pointer that moves
//                    past each granted source); undefined = fixed priority,
//                    source 0 highest.
//
// Ports:
//   CLK, RESET_n       clock, synchronous active-low reset
//   req[NSRC]          level requests, active high
//   M1_n, IORQ_n       Z80 cycle type (both low = interrupt acknowledge)
//   RD_n, WR_n         Z80 read/write strobes for the mask/status IO ports
//   A_io[8], D_in[8]   Z80 low address byte and incoming data
//   INT_n              registered interrupt request to the CPU
//   vec_oe, vec_out    vector drive enable and vector value
//   io_rd_sel          high during IN from the mask or status port
//   io_rd_data         mask, or status (masked pending requests)
//   ack[NSRC]          one-cycle one-hot pulse for the granted source

module z80_int_arbiter #(
  parameter int                NSRC         = 4,
  parameter logic [8*NSRC-1:0] VECTORS      = {8'hFF, 8'hF7, 8'hEF, 8'h6C},
  parameter logic [7:0]        VEC_SPURIOUS = 8'hFF,
  parameter logic [7:0]        MASK_RST     = 8'h01,
  parameter logic [7:0]        IOADDR_MASK  = 8'h02,
  parameter logic [7:0]        IOADDR_STAT  = 8'h03,
  parameter int                HOLDOFF      = 2
) (
  input  logic            CLK,
  input  logic            RESET_n,
  input  logic [NSRC-1:0] req,
  input  logic            M1_n,
  input  logic            IORQ_n,
  input  logic            RD_n,
  input  logic            WR_n,
  input  logic [7:0]      A_io,
  input  logic [7:0]      D_in,
  output logic            INT_n,
  output logic            vec_oe,
  output logic [7:0]      vec_out,
  output logic            io_rd_sel,
  output logic [7:0]      io_rd_data,
  output logic [NSRC-1:0] ack
);

  localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int HCW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]      r_state;
  logic            r_int_n;
  logic            r_vec_oe;
  logic [7:0]      r_vec_out;
  logic [NSRC-1:0] r_ack;
  logic [7:0]      r_mask;
  logic [NSRC-1:0] r_pend;
  logic            r_wr_d;
  logic [HCW-1:0]  r_hcnt;
`ifdef INT_RR_PRIO_EN
  logic [IDXW-1:0] r_ptr;
`endif

  logic            w_inta;
  logic            w_wr_cyc;
  logic            w_gnt_vld;
  logic [IDXW-1:0] w_gnt_idx;
  logic [NSRC-1:0] w_gnt_oh;
  logic [7:0]      w_stat;

  assign w_inta   = ~M1_n & ~IORQ_n;
  assign w_wr_cyc = ~IORQ_n & ~WR_n & M1_n & (A_io == IOADDR_MASK);

  assign io_rd_sel  = ~IORQ_n & ~RD_n & M1_n &
                      ((A_io == IOADDR_MASK) | (A_io == IOADDR_STAT));
  assign io_rd_data = (A_io == IOADDR_STAT) ? w_stat : r_mask;

  assign INT_n   = r_int_n;
  assign vec_oe  = r_vec_oe;
  assign vec_out = r_vec_out;
  assign ack     = r_ack;

  // Status byte: live masked requests, plus the rotation pointer in the top bits.
  always_comb begin
    w_stat = 8'h00;
    for (int i = 0; i < NSRC; i++) begin
      w_stat[i] = req[i] & r_mask[i];
    end
`ifdef INT_RR_PRIO_EN
    if (NSRC <= 5) begin
      w_stat[7:5] = 3'(r_ptr);
    end else begin
      w_stat = w_stat;
    end
`endif
  end

  // Winner selection over registered pend. The loop walks the search order
  // backwards so the last hit (the first in search order) wins.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
`ifdef INT_RR_PRIO_EN
      j = int'(r_ptr) + k;
      if (j >= NSRC) begin
        j = j - NSRC;
      end else begin
        j = j;
      end
`else
      j = k;
`endif
      if (r_pend[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDXW'(j);
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
    w_gnt_oh[w_gnt_idx] = w_gnt_vld;
  end

  // Mask register, pend pipeline, and the request/acknowledge state machine.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      r_state   <= ST_IDLE;
      r_int_n   <= 1'b1;
      r_vec_oe  <= 1'b0;
      r_vec_out <= 8'h00;
      r_ack     <= '0;
      r_mask    <= MASK_RST;
      r_pend    <= '0;
      r_wr_d    <= 1'b0;
      r_hcnt    <= '0;
`ifdef INT_RR_PRIO_EN
      r_ptr     <= '0;
`endif
    end else begin
      // Write only on the first clock of the bus cycle.
      r_wr_d <= w_wr_cyc;
      if (w_wr_cyc && !r_wr_d) begin
        r_mask <= D_in;
      end
      r_pend <= req & r_mask[NSRC-1:0];
      r_ack  <= '0;

      case (r_state)
        ST_IDLE: begin
          r_int_n <= 1'b1;
          if (|r_pend) begin
            r_state <= ST_REQ;
            r_int_n <= 1'b0;
          end
        end
        ST_REQ: begin
          if (w_inta) begin
            r_state  <= ST_ACK;
            r_int_n  <= 1'b1;
            r_vec_oe <= 1'b1;
            if (w_gnt_vld) begin
              r_vec_out <= VECTORS[{w_gnt_idx, 3'b000} +: 8];
              r_ack     <= w_gnt_oh;
`ifdef INT_RR_PRIO_EN
              r_ptr <= (w_gnt_idx == IDXW'(NSRC - 1)) ? '0 : w_gnt_idx + 1'b1;
`endif
            end else begin
              r_vec_out <= VEC_SPURIOUS;
            end
          end else if (~|r_pend) begin
            // Request withdrawn (source dropped or masked) before acknowledge.
            r_state <= ST_IDLE;
            r_int_n <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!w_inta) begin
            r_vec_oe <= 1'b0;
            r_hcnt   <= '0;
            r_state  <= (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Give the ISR time to clear the source before re-arbitrating.
          if (r_hcnt == HCW'(HOLDOFF - 1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_int_n  <= 1'b1;
          r_vec_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_int_arbiter.sv
// Self-checking bench for z80_int_arbiter (default parameters, NSRC=4).
// Directed scenarios followed by randomized request/mask traffic, checked
// against a transaction-level model of mask, priority and vectors.
// Build with INT_RR_PRIO_EN defined to exercise rotating priority.

module tb_z80_int_arbiter;

  localparam logic [7:0] A_MASK = 8'h02;
  localparam logic [7:0] A_STAT = 8'h03;
  localparam logic [7:0] SPUR   = 8'hFF;
  localparam int         HOLD   = 2;

  logic       CLK;
  logic       RESET_n;
  logic [3:0] req;
  logic       M1_n, IORQ_n, RD_n, WR_n;
  logic [7:0] A_io, D_in;
  logic       INT_n, vec_oe, io_rd_sel;
  logic [7:0] vec_out, io_rd_data;
  logic [3:0] ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [7:0] m_mask;
  int         m_ptr;
  logic [7:0] vtab [4] = '{8'h6C, 8'hEF, 8'hF7, 8'hFF};

  z80_int_arbiter dut (
    .CLK(CLK), .RESET_n(RESET_n), .req(req), .M1_n(M1_n), .IORQ_n(IORQ_n),
    .RD_n(RD_n), .WR_n(WR_n), .A_io(A_io), .D_in(D_in), .INT_n(INT_n),
    .vec_oe(vec_oe), .vec_out(vec_out), .io_rd_sel(io_rd_sel),
    .io_rd_data(io_rd_data), .ack(ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Winner by the priority rules: first pending source from the search start.
  function automatic int model_grant(input logic [3:0] p);
    int start;
`ifdef INT_RR_PRIO_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (p[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_stat(input logic [3:0] r);
    logic [7:0] s;
    s = {4'h0, r & m_mask[3:0]};
`ifdef INT_RR_PRIO_EN
    s[7:5] = 3'(m_ptr);
`endif
    return s;
  endfunction

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    A_io = a; D_in = d; M1_n = 1'b1; IORQ_n = 1'b0; WR_n = 1'b0;
    tick();
    D_in = ~d;           // later clocks of the same cycle must not write
    tick();
    tick();
    IORQ_n = 1'b1; WR_n = 1'b1;
    tick();
    if (a == A_MASK) m_mask = d;
  endtask

  task automatic io_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    A_io = a; M1_n = 1'b1; IORQ_n = 1'b0; RD_n = 1'b0;
    #1;
    check_eq({tag, "_sel"}, io_rd_sel, 1'b1);
    check_eq({tag, "_data"}, io_rd_data, exp);
    IORQ_n = 1'b1; RD_n = 1'b0;
    #1;
    check_eq({tag, "_nosel"}, io_rd_sel, 1'b0);
    RD_n = 1'b1;
    tick();
  endtask

  task automatic wait_int(input string tag, input int budget);
    int n;
    n = 0;
    while (INT_n !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, INT_n, 1'b0);
  endtask

  // Full acknowledge: p is the pending set at the grant edge, req_after is
  // applied when INTA ends. Checks vector, ack pulse, holdoff and re-request.
  task automatic do_inta(input string tag, input logic [3:0] p, input logic [3:0] req_after);
    int g;
    logic [7:0] ev;
    logic [3:0] ea;
    g  = model_grant(p);
    ev = (g >= 0) ? vtab[g] : SPUR;
    ea = (g >= 0) ? 4'(1 << g) : 4'h0;
    M1_n = 1'b0; IORQ_n = 1'b0;
    tick();
    check_eq({tag, "_oe"}, vec_oe, 1'b1);
    check_eq({tag, "_vec"}, vec_out, ev);
    check_eq({tag, "_ack"}, ack, ea);
    check_eq({tag, "_int_ack"}, INT_n, 1'b1);
    if (g >= 0) m_ptr = (g + 1) % 4;
    tick();
    check_eq({tag, "_ack_pulse"}, ack, 4'h0);
    check_eq({tag, "_oe_hold"}, vec_oe, 1'b1);
    M1_n = 1'b1; IORQ_n = 1'b1; req = req_after;
    tick();
    check_eq({tag, "_oe_off"}, vec_oe, 1'b0);
    check_eq({tag, "_int_h0"}, INT_n, 1'b1);
    for (int i = 0; i < HOLD; i++) begin
      tick();
      check_eq({tag, "_int_hold"}, INT_n, 1'b1);
    end
    tick();
    check_eq({tag, "_rereq"}, INT_n, ~|(req_after & m_mask[3:0]));
  endtask

  initial begin
    logic [3:0] r;
    logic [7:0] mv;
    m_mask = 8'h01; m_ptr = 0;
    RESET_n = 1'b0; req = 4'hF; M1_n = 1'b1; IORQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
    A_io = 8'h00; D_in = 8'h00;

    // T1 reset
    repeat (3) tick();
    check_eq("t1_int", INT_n, 1'b1);
    check_eq("t1_oe", vec_oe, 1'b0);
    check_eq("t1_ack", ack, 4'h0);
    check_eq("t1_vec", vec_out, 8'h00);
    io_read("t1_mask", A_MASK, 8'h01);
    req = 4'h0; RESET_n = 1'b1;
    tick(); tick();

    // T2 single source
    req = 4'b0001;
    tick(); check_eq("t2_lat1", INT_n, 1'b1);
    tick(); check_eq("t2_lat2", INT_n, 1'b0);
    do_inta("t2", 4'b0001, 4'b0000);

    // T3 fixed priority / drop highest
    io_write(A_MASK, 8'h0F);
    io_read("t3_mask", A_MASK, 8'h0F);
    req = 4'b1010;
    tick(); tick(); check_eq("t3_int", INT_n, 1'b0);
    do_inta("t3a", 4'b1010, 4'b1000);
    do_inta("t3b", 4'b1000, 4'b0000);

    // T4 withdrawal, then spurious acknowledge
    req = 4'b0001;
    tick(); tick(); check_eq("t4_int", INT_n, 1'b0);
    req = 4'b0000;
    tick(); check_eq("t4_still", INT_n, 1'b0);
    tick(); check_eq("t4_release", INT_n, 1'b1);
    req = 4'b0001;
    tick(); tick(); check_eq("t4_int2", INT_n, 1'b0);
    req = 4'b0000;
    tick();
    do_inta("t4_spur", 4'b0000, 4'b0000);

    // T5 masking
    io_write(A_MASK, 8'h00);
    req = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick(); check_eq("t5_masked", INT_n, 1'b1);
    end
    io_read("t5_stat", A_STAT, model_stat(4'hF));
    io_write(A_MASK, 8'h04);
    wait_int("t5_int", 4);
    do_inta("t5", 4'b0100, 4'b0000);

    // T6 all sources held, four acknowledges
    io_write(A_MASK, 8'h0F);
    req = 4'hF;
    tick(); tick(); check_eq("t6_int", INT_n, 1'b0);
    for (int i = 0; i < 3; i++) do_inta("t6", 4'hF, 4'hF);
    do_inta("t6_last", 4'hF, 4'h0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        mv = 8'($urandom_range(0, 255));
        io_write(A_MASK, mv);
        io_read("rnd_mask", A_MASK, m_mask);
      end
      r = 4'($urandom_range(0, 15));
      req = r;
      tick(); check_eq("rnd_lat1", INT_n, 1'b1);
      tick(); check_eq("rnd_lat2", INT_n, ~|(r & m_mask[3:0]));
      io_read("rnd_stat", A_STAT, model_stat(r));
      if ((r & m_mask[3:0]) != 4'h0) begin
        repeat ($urandom_range(0, 2)) begin
          tick(); check_eq("rnd_wait", INT_n, 1'b0);
        end
        do_inta("rnd", r & m_mask[3:0], 4'h0);
      end else begin
        req = 4'h0;
        tick(); tick();
        check_eq("rnd_idle", INT_n, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
